smi_axi_write_slave: RTL and testbench



---
 rtl/smi_pkg.sv | 25 ++
 rtl/smi_frame_packer.sv | 49 ++++
 rtl/smi_axi_write_slave.sv | 123 ++++++++++++
 tb/tb_smi_axi_write_slave.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/smi_pkg.sv
// smi_pkg: SMI write-protocol constants, header layout and header builder
package smi_pkg;
  localparam logic [7:0] WRITE_REQ_ID_BYTE  = 8'h01;
  localparam logic [7:0] WRITE_RESP_ID_BYTE = 8'hFE;
  localparam int SMI_HEADER_BYTES = 14;
  localparam int HDR_ID_OFS    = 0;
  localparam int HDR_FLAGS_OFS = 1;
  localparam int HDR_TAG_OFS   = 2;
  localparam int HDR_ADDR_OFS  = 4;
  localparam int HDR_LEN_OFS   = 12;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  typedef logic [SMI_HEADER_BYTES*8-1:0] smi_hdr_t;
  function automatic smi_hdr_t smi_write_hdr(input logic [7:0] flags, input logic [15:0] tag,
                                             input logic [63:0] addr, input logic [15:0] blen);
    smi_hdr_t h;
    h = '0;
    h[HDR_ID_OFS*8 +: 8]     = WRITE_REQ_ID_BYTE;
    h[HDR_FLAGS_OFS*8 +: 8]  = flags;
    h[HDR_TAG_OFS*8 +: 16]   = tag;
    h[HDR_ADDR_OFS*8 +: 64]  = addr;
    h[HDR_LEN_OFS*8 +: 16]   = blen;
    return h;
  endfunction
endpackage

// File: rtl/smi_frame_packer.sv
// smi_frame_packer: shifts W beats behind the SMI header and holds each flit until the network accepts it
module smi_frame_packer
  import smi_pkg::*;
#(
  parameter int DataWidth = 128
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 beat_valid,
  input  logic                 beat_first,
  input  logic [DataWidth-1:0] beat_data,
  input  smi_hdr_t             hdr,
  input  logic                 tail_valid,
  input  logic                 smiReqStop,
  output logic                 free,
  output logic                 smiReqReady,
  output logic [7:0]           smiReqEofc,
  output logic [DataWidth-1:0] smiReqData
);
  localparam int HW = DataWidth - SMI_HEADER_BYTES * 8;
  logic                 valid_q, valid_d;
  logic [7:0]           eofc_q, eofc_d;
  logic [DataWidth-1:0] data_q, data_d;
  smi_hdr_t             carry_q, carry_d;
  always_comb begin
    free    = ~valid_q | ~smiReqStop;
    valid_d = beat_valid | tail_valid | (valid_q & ~free);
    eofc_d  = tail_valid ? 8'(SMI_HEADER_BYTES) : beat_valid ? 8'd0 : eofc_q;
    data_d  = beat_valid ? {beat_data[HW-1:0], beat_first ? hdr : carry_q} :
              tail_valid ? {{HW{1'b0}}, carry_q} : data_q;
    carry_d = beat_valid ? beat_data[DataWidth-1:HW] : carry_q;
  end
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      valid_q <= 1'b0;
      eofc_q  <= '0;
      data_q  <= '0;
      carry_q <= '0;
    end else begin
      valid_q <= valid_d;
      eofc_q  <= eofc_d;
      data_q  <= data_d;
      carry_q <= carry_d;
    end
  end
  assign smiReqReady = valid_q;
  assign smiReqEofc  = eofc_q;
  assign smiReqData  = data_q;
endmodule

// File: rtl/smi_axi_write_slave.sv
// smi_axi_write_slave: AXI4 write bursts to SMI write frames and back; SMI_RESP_FRAME_CHECK_EN drops malformed responses
module smi_axi_write_slave
  import smi_pkg::*;
#(
  parameter int DataIndexSize        = 4,
  parameter int AxiIdWidth           = 4,
  parameter int MaxOutstanding       = 16,
  parameter int OutstandingIndexSize = 5,
  localparam int DataWidth           = 8 << DataIndexSize
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic                    axiAWValid,
  output logic                    axiAWReady,
  input  logic [AxiIdWidth-1:0]   axiAWId,
  input  logic [63:0]             axiAWAddr,
  input  logic [7:0]              axiAWLen,
  input  logic [2:0]              axiAWSize,
  input  logic [3:0]              axiAWCache,
  input  logic                    axiWValid,
  output logic                    axiWReady,
  input  logic [DataWidth-1:0]    axiWData,
  input  logic [DataWidth/8-1:0]  axiWStrb,
  input  logic                    axiWLast,
  output logic                    axiBValid,
  input  logic                    axiBReady,
  output logic [AxiIdWidth-1:0]   axiBId,
  output logic [1:0]              axiBResp,
  output logic                    smiReqReady,
  output logic [7:0]              smiReqEofc,
  output logic [DataWidth-1:0]    smiReqData,
  input  logic                    smiReqStop,
  input  logic                    smiRespReady,
  input  logic [7:0]              smiRespEofc,
  input  logic [DataWidth-1:0]    smiRespData,
  output logic                    smiRespStop
);
  localparam logic [1:0] IDLE = 2'd0, DATA = 2'd1, TAIL = 2'd2;
  logic [1:0]                      state_q, state_d;
  logic [7:0]                      cnt_q, cnt_d;
  smi_hdr_t                        hdr_q, hdr_d;
  logic                            first_q, first_d;
  logic                            started_q;
  logic [OutstandingIndexSize-1:0] out_q, out_d;
  logic                            bvalid_q, bvalid_d;
  logic [AxiIdWidth-1:0]           bid_q, bid_d;
  logic [1:0]                      bresp_q, bresp_d;
  logic                            free, tail_valid, aw_hs, w_hs, b_hs, rsp_hs, rsp_ok, aw_err;
  logic [15:0]                     blen;
  logic                            unused_ok;
  assign unused_ok = ^{axiWStrb, axiWLast, axiAWCache[3:1], smiRespEofc, smiRespData};
`ifdef SMI_RESP_FRAME_CHECK_EN
  logic [15:0] drop_q, drop_d;
  assign rsp_ok = (smiRespData[7:0] == WRITE_RESP_ID_BYTE) & (smiRespEofc == 8'd4);
  assign drop_d = drop_q + 16'(rsp_hs & ~rsp_ok & ~&drop_q);
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) drop_q <= '0;
    else       drop_q <= drop_d;
  end
`else
  assign rsp_ok = 1'b1;
`endif
  always_comb begin
    aw_err     = (axiAWSize != 3'(DataIndexSize)) | (|axiAWAddr[DataIndexSize-1:0]);
    blen       = (16'(axiAWLen) + 16'd1) << DataIndexSize;
    axiAWReady = started_q & (state_q == IDLE) & (out_q < OutstandingIndexSize'(MaxOutstanding));
    axiWReady  = started_q & (state_q == DATA) & free;
    aw_hs      = axiAWValid & axiAWReady;
    w_hs       = axiWValid & axiWReady;
    tail_valid = (state_q == TAIL) & free;
    b_hs       = bvalid_q & axiBReady;
    rsp_hs     = smiRespReady & ~bvalid_q;
    state_d    = aw_hs ? DATA : (w_hs & (cnt_q == 8'd0)) ? TAIL : tail_valid ? IDLE : state_q;
    cnt_d      = aw_hs ? axiAWLen : w_hs ? cnt_q - 8'd1 : cnt_q;
    first_d    = aw_hs | (first_q & ~w_hs);
    hdr_d      = aw_hs ? smi_write_hdr({7'd0, ~axiAWCache[0]}, {aw_err, 15'(axiAWId)}, axiAWAddr, blen) : hdr_q;
    out_d      = out_q + OutstandingIndexSize'(aw_hs) - OutstandingIndexSize'(b_hs);
    bvalid_d   = rsp_hs ? rsp_ok : bvalid_q & ~b_hs;
    bid_d      = (rsp_hs & rsp_ok) ? smiRespData[16 +: AxiIdWidth] : bid_q;
    bresp_d    = (rsp_hs & rsp_ok) ? (smiRespData[31] ? AXI_RESP_SLVERR : smiRespData[9:8]) : bresp_q;
  end
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hdr_q     <= '0;
      first_q   <= 1'b0;
      started_q <= 1'b0;
      out_q     <= '0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= AXI_RESP_OKAY;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hdr_q     <= hdr_d;
      first_q   <= first_d;
      started_q <= 1'b1;
      out_q     <= out_d;
      bvalid_q  <= bvalid_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
    end
  end
  smi_frame_packer #(.DataWidth(DataWidth)) u_packer (
    .clk        (clk),
    .nrst       (nrst),
    .beat_valid (w_hs),
    .beat_first (first_q),
    .beat_data  (axiWData),
    .hdr        (hdr_q),
    .tail_valid (tail_valid),
    .smiReqStop (smiReqStop),
    .free       (free),
    .smiReqReady(smiReqReady),
    .smiReqEofc (smiReqEofc),
    .smiReqData (smiReqData)
  );
  assign axiBValid   = bvalid_q;
  assign axiBId      = bid_q;
  assign axiBResp    = bresp_q;
  assign smiRespStop = bvalid_q;
endmodule

// File: tb/tb_smi_axi_write_slave.sv
// tb_smi_axi_write_slave: randomized AXI bursts checked against a byte-stream frame model and a B-response scoreboard
module tb_smi_axi_write_slave;
  logic         clk = 1'b0, nrst = 1'b0;
  logic         axiAWValid, axiAWReady, axiWValid, axiWReady, axiWLast, axiBValid, axiBReady;
  logic [3:0]   axiAWId, axiAWCache, axiBId;
  logic [63:0]  axiAWAddr;
  logic [7:0]   axiAWLen, smiReqEofc, smiRespEofc;
  logic [2:0]   axiAWSize;
  logic [127:0] axiWData, smiReqData, smiRespData;
  logic [15:0]  axiWStrb;
  logic [1:0]   axiBResp;
  logic         smiReqReady, smiReqStop, smiRespReady, smiRespStop;
  always #5 clk = ~clk;
  smi_axi_write_slave dut (
    .clk(clk), .nrst(nrst),
    .axiAWValid(axiAWValid), .axiAWReady(axiAWReady), .axiAWId(axiAWId), .axiAWAddr(axiAWAddr),
    .axiAWLen(axiAWLen), .axiAWSize(axiAWSize), .axiAWCache(axiAWCache),
    .axiWValid(axiWValid), .axiWReady(axiWReady), .axiWData(axiWData), .axiWStrb(axiWStrb), .axiWLast(axiWLast),
    .axiBValid(axiBValid), .axiBReady(axiBReady), .axiBId(axiBId), .axiBResp(axiBResp),
    .smiReqReady(smiReqReady), .smiReqEofc(smiReqEofc), .smiReqData(smiReqData), .smiReqStop(smiReqStop),
    .smiRespReady(smiRespReady), .smiRespEofc(smiRespEofc), .smiRespData(smiRespData), .smiRespStop(smiRespStop)
  );
  typedef struct { logic [127:0] data; logic [127:0] mask; logic [7:0] eofc; } flit_t;
  typedef struct { logic [15:0] tag; logic [1:0] status; } rsp_t;
  typedef struct { logic [3:0] id; logic [1:0] resp; } b_t;
  flit_t        exp_q[$];
  logic [15:0]  pend[$];
  rsp_t         rsp_q[$];
  b_t           b_exp[$];
  logic [127:0] wbeats[$];
  int           errors = 0, checks = 0, smode = 0, bmode = 0, bdone = 0;
  bit           rsp_busy = 0;
  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic aw_phase(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [3:0] cache, input logic [15:0] lo0);
    logic [7:0]   q[$];
    logic [15:0]  tag, blen;
    logic [127:0] b;
    flit_t        f;
    bit           ok;
    tag  = {(addr % 64'd16 != 64'd0) || (size != 3'd4), 11'd0, id};
    blen = 16'((int'(len) + 1) * 16);
    wbeats.delete();
    q.push_back(8'h01);
    q.push_back({7'd0, ~cache[0]});
    q.push_back(tag[7:0]);
    q.push_back(tag[15:8]);
    for (int i = 0; i < 8; i++) q.push_back(addr[8*i +: 8]);
    q.push_back(blen[7:0]);
    q.push_back(blen[15:8]);
    for (int k = 0; k <= int'(len); k++) begin
      b = {$urandom, $urandom, $urandom, $urandom};
      if (k == 0) b[15:0] = lo0;
      wbeats.push_back(b);
      for (int i = 0; i < 16; i++) q.push_back(b[8*i +: 8]);
    end
    for (int k = 0; k <= int'(len) + 1; k++) begin
      f.data = '0;
      f.mask = '0;
      f.eofc = (k == int'(len) + 1) ? 8'd14 : 8'd0;
      for (int i = 0; i < 16; i++)
        if (16 * k + i < q.size()) begin
          f.data[8*i +: 8] = q[16*k+i];
          f.mask[8*i +: 8] = 8'hFF;
        end
      exp_q.push_back(f);
    end
    pend.push_back(tag);
    axiAWValid = 1'b1; axiAWId = id; axiAWAddr = addr; axiAWLen = len; axiAWSize = size; axiAWCache = cache;
    ok = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      ok = axiAWReady;
      @(posedge clk);
    end
    #1 axiAWValid = 1'b0;
    if (!ok) check("aw_timeout", 160'(axiAWReady), 160'(1));
  endtask
  task automatic w_beat(input logic [127:0] d, input bit last);
    bit ok;
    axiWValid = 1'b1; axiWData = d; axiWLast = last;
    ok = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      ok = axiWReady;
      @(posedge clk);
    end
    #1 axiWValid = 1'b0;
    if (!ok) check("w_timeout", 160'(axiWReady), 160'(1));
  endtask
  task automatic burst(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                       input logic [2:0] size, input logic [3:0] cache, input bit gaps);
    aw_phase(id, addr, len, size, cache, 16'($urandom));
    for (int k = 0; k < wbeats.size(); k++) begin
      if (gaps && $urandom % 3 == 0) begin
        repeat ($urandom % 3) @(posedge clk);
        #1;
      end
      w_beat(wbeats[k], k == wbeats.size() - 1);
    end
  endtask
  task automatic release_rsp(input int n);
    rsp_t r;
    for (int i = 0; i < n && pend.size() != 0; i++) begin
      r.tag = pend.pop_front();
      r.status = 2'($urandom);
      rsp_q.push_back(r);
    end
  endtask
  task automatic drain();
    for (int i = 0; i < 3000 && !(exp_q.size() == 0 && rsp_q.size() == 0 && b_exp.size() == 0 && !axiBValid && !rsp_busy); i++)
      @(posedge clk);
    #1;
    check("drain_flits", 160'(exp_q.size()), 160'(0));
    check("drain_b", 160'(b_exp.size()), 160'(0));
  endtask
  initial begin
    smiReqStop = 1'b0;
    forever begin
      @(posedge clk);
      #1 smiReqStop = smode == 1 ? ~smiReqStop : smode == 2 ? ($urandom % 3 == 0) : 1'b0;
    end
  end
  initial begin
    axiBReady = 1'b1;
    forever begin
      @(posedge clk);
      #1 axiBReady = bmode == 0 ? 1'b1 : bmode == 2 ? 1'b0 : 1'($urandom);
    end
  end
  initial begin
    rsp_t r;
    b_t   e;
    bit   sent;
    smiRespReady = 1'b0; smiRespEofc = '0; smiRespData = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rsp_q.size() != 0 && nrst) begin
        r = rsp_q.pop_front();
        rsp_busy = 1;
        smiRespData = '0;
        smiRespData[7:0] = 8'hFE;
        smiRespData[9:8] = r.status;
        smiRespData[31:16] = r.tag;
        smiRespEofc = 8'd4;
        smiRespReady = 1'b1;
        sent = 0;
        for (int i = 0; i < 1000 && !sent; i++) begin
          @(negedge clk);
          if (!smiRespStop) begin
            sent = 1;
            e.id = r.tag[3:0];
            e.resp = r.tag[15] ? 2'b10 : r.status;
            b_exp.push_back(e);
          end
          @(posedge clk);
        end
        #1 smiRespReady = 1'b0;
        rsp_busy = 0;
        if (!sent) check("rsp_timeout", 160'(smiRespStop), 160'(0));
      end
    end
  end
  logic         stalled = 0;
  logic [135:0] held;
  flit_t        mf;
  always @(negedge clk) begin
    if (!nrst) stalled = 0;
    else begin
      if (stalled) check("stall_hold", 160'({smiReqReady, smiReqEofc, smiReqData}), 160'({1'b1, held}));
      stalled = 0;
      if (smiReqReady && smiReqStop) begin
        stalled = 1;
        held = {smiReqEofc, smiReqData};
      end else if (smiReqReady) begin
        if (exp_q.size() == 0) check("flit_extra", 160'(smiReqReady), 160'(0));
        else begin
          mf = exp_q.pop_front();
          check("flit_data", 160'(smiReqData & mf.mask), 160'(mf.data));
          check("flit_eofc", 160'(smiReqEofc), 160'(mf.eofc));
        end
      end
    end
  end
  b_t be;
  always @(negedge clk) begin
    if (nrst && axiBValid && axiBReady) begin
      if (b_exp.size() == 0) check("b_extra", 160'(axiBValid), 160'(0));
      else begin
        be = b_exp.pop_front();
        check("b_id", 160'(axiBId), 160'(be.id));
        check("b_resp", 160'(axiBResp), 160'(be.resp));
      end
      bdone++;
    end
  end
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int bd0;
    axiAWValid = 0; axiAWId = 0; axiAWAddr = 0; axiAWLen = 0; axiAWSize = 0; axiAWCache = 0;
    axiWValid = 0; axiWData = 0; axiWStrb = '1; axiWLast = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_awready", 160'(axiAWReady), 160'(0));
    check("rst_wready", 160'(axiWReady), 160'(0));
    check("rst_bvalid", 160'(axiBValid), 160'(0));
    check("rst_reqready", 160'(smiReqReady), 160'(0));
    check("rst_respstop", 160'(smiRespStop), 160'(0));
    @(posedge clk);
    #1 nrst = 1'b1;
    @(negedge clk);
    check("gate_awready", 160'(axiAWReady), 160'(0));
    @(posedge clk);
    #1 check("awready_up", 160'(axiAWReady), 160'(1));
    aw_phase(4'd3, 64'h1000, 8'd0, 3'd4, 4'h1, 16'hBBAA);
    check("lat_before", 160'(smiReqReady), 160'(0));
    w_beat(wbeats[0], 1);
    @(negedge clk);
    check("lat_flit0", 160'(smiReqReady), 160'(1));
    check("flit0_bytes", 160'(smiReqData), 160'(128'hBBAA_0010_0000_0000_0000_1000_0003_0001));
    check("flit0_eofc", 160'(smiReqEofc), 160'(0));
    release_rsp(1);
    drain();
    smode = 1;
    burst(4'd5, 64'h2000, 8'd3, 3'd4, 4'h1, 0);
    release_rsp(1);
    drain();
    smode = 0;
    burst(4'd6, 64'h1004, 8'd0, 3'd4, 4'h0, 0);
    begin
      rsp_t r;
      r.tag = pend.pop_front();
      r.status = 2'b00;
      rsp_q.push_back(r);
    end
    drain();
    repeat (16) burst(4'($urandom), {$urandom, $urandom} & ~64'hF, 8'd0, 3'd4, 4'($urandom), 0);
    drain();
    check("aw_full", 160'(axiAWReady), 160'(0));
    bd0 = bdone;
    release_rsp(1);
    for (int i = 0; i < 200 && bdone == bd0; i++) @(posedge clk);
    @(negedge clk);
    check("aw_reopen", 160'(axiAWReady), 160'(1));
    bmode = 2;
    void'(pend.pop_front());
    begin
      rsp_t r;
      r.tag = 16'h0005;
      r.status = 2'b11;
      rsp_q.push_back(r);
    end
    for (int i = 0; i < 200 && !axiBValid; i++) @(negedge clk);
    repeat (5) begin
      @(negedge clk);
      check("hold_stop", 160'(smiRespStop), 160'(1));
      check("hold_bid", 160'(axiBId), 160'(5));
      check("hold_bresp", 160'(axiBResp), 160'(3));
    end
    bmode = 0;
    release_rsp(pend.size());
    drain();
    smode = 2;
    bmode = 1;
    for (int n = 0; n < 30; n++) begin
      burst(4'($urandom), ({$urandom, $urandom} & ~64'hF) | (($urandom % 5 == 0) ? 64'($urandom % 16) : 64'd0),
            8'($urandom % 8), ($urandom % 6 == 0) ? 3'($urandom) : 3'd4, 4'($urandom), 1);
      if (pend.size() >= 8) release_rsp(pend.size());
      else if ($urandom % 2 == 1) release_rsp(2);
    end
    release_rsp(pend.size());
    drain();
    smode = 0;
    bmode = 0;
    @(posedge clk);
    #1;
    aw_phase(4'd2, 64'h3000, 8'd7, 3'd4, 4'h1, 16'($urandom));
    w_beat(wbeats[0], 0);
    w_beat(wbeats[1], 0);
    axiWValid = 1'b1;
    axiWData = wbeats[2];
    @(posedge clk);
    #2 nrst = 1'b0;
    #1;
    check("arst_reqready", 160'(smiReqReady), 160'(0));
    check("arst_awready", 160'(axiAWReady), 160'(0));
    check("arst_wready", 160'(axiWReady), 160'(0));
    check("arst_bvalid", 160'(axiBValid), 160'(0));
    exp_q.delete();
    pend.delete();
    axiWValid = 1'b0;
    @(posedge clk);
    #1 nrst = 1'b1;
    @(negedge clk);
    check("regate_awready", 160'(axiAWReady), 160'(0));
    @(posedge clk);
    #1;
    burst(4'd9, 64'h4000, 8'd2, 3'd4, 4'h0, 0);
    release_rsp(1);
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
